// File: rtl/apb_completer_regs.sv
// rtl/apb_completer_regs.sv - APB completer with programmable wait states and a word-addressed register file
module apb_completer_regs #(
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   input  logic [3:0]  pstrb,
   output logic        pready,
   output logic [31:0] prdata,
   output logic        pslverr
);

   localparam int IW = $clog2(NUM_REGS);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic           setup, complete;

   logic [IW-1:0]  cap_idx;
   logic           cap_write;
   logic           cap_err;
   logic [31:0]    cap_wdata;
   logic [3:0]     cap_strb;

   logic [31:0]    regs [NUM_REGS];
   logic [29:0]    idx;
   logic           req_err;
   logic [31:0]    rd_word;
   logic           unused_addr_lsbs;

   assign idx              = paddr[31:2];
   assign unused_addr_lsbs = ^paddr[1:0];
   assign req_err          = ({2'b00, idx} >= 32'(NUM_REGS)) || (pwrite && (idx == '0));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      setup     = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               setup     = 1'b1;
               cnt_nxt   = 4'(WAIT_CYCLES);
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_nxt = IDLE;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - 4'd1;
            end else if (penable) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Everything the transfer needs is frozen at SETUP; the bus may change during ACCESS.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cap_idx   <= '0;
         cap_write <= 1'b0;
         cap_err   <= 1'b0;
         cap_wdata <= '0;
         cap_strb  <= '0;
      end else if (setup) begin
         cap_idx   <= idx[IW-1:0];
         cap_write <= pwrite;
         cap_err   <= req_err;
         cap_wdata <= pwdata;
         cap_strb  <= pstrb;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (complete && cap_write && !cap_err) begin
         for (int b = 0; b < 4; b++) begin
            if (cap_strb[b]) begin
               regs[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
            end
         end
      end
   end

   // Entry 0 of regs is never written; the ID constant stands in for it.
   assign rd_word = (cap_idx == '0) ? ID_VALUE : regs[cap_idx];
   assign pready  = (state == ACCESS) && psel && penable && (cnt == '0);
   assign pslverr = pready && cap_err;
   assign prdata  = (pready && !cap_write && !cap_err) ? rd_word : '0;

endmodule

// File: tb/tb_apb_completer_regs.sv
// tb/tb_apb_completer_regs.sv - scoreboard bench for apb_completer_regs at three wait-state settings
module tb_apb_completer_regs;

   localparam logic [31:0] ID = 32'hA5B0_0001;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic [2:0]  psel = '0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;

   logic        pready_v  [3];
   logic [31:0] prdata_v  [3];
   logic        pslverr_v [3];
   int          waits     [3] = '{2, 0, 3};

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   always #5 pclk = ~pclk;

   apb_completer_regs #(.NUM_REGS(8), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut_w2 (
      .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0]));

   apb_completer_regs #(.NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut_w0 (
      .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1]));

   apb_completer_regs #(.NUM_REGS(8), .WAIT_CYCLES(3), .ID_VALUE(ID)) dut_w3 (
      .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready_v[2]), .prdata(prdata_v[2]), .pslverr(pslverr_v[2]));

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkint(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Full transfer; leaves psel/penable high so a following call runs back-to-back.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [31:0] exp_rd, input bit exp_err,
                       input string tag);
      exp_t e;
      int   n;
      @(posedge pclk); #1;
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      sb.push_back('{tag, exp_rd, exp_err, waits[d]});
      @(posedge pclk); #1;
      penable = 1'b1;
      paddr   = ~addr;
      pwdata  = ~data;
      n = 0;
      @(negedge pclk);
      while (!pready_v[d] && n < 40) begin
         n++;
         @(negedge pclk);
      end
      e = sb.pop_front();
      checkint({e.tag, " wait"}, n, e.lat);
      check32({e.tag, " prdata"}, prdata_v[d], e.rdata);
      check32({e.tag, " pslverr"}, 32'(pslverr_v[d]), 32'(e.err));
   endtask

   // Holds psel&penable through one IDLE edge (must be ignored), then releases the bus.
   task automatic go_idle(input int d, input string tag);
      @(negedge pclk);
      check32({tag, " pready one cycle"}, 32'(pready_v[d]), 32'd0);
      @(negedge pclk);
      check32({tag, " idle penable ignored"}, 32'(pready_v[d]), 32'd0);
      #1;
      psel    = '0;
      penable = 1'b0;
   endtask

   initial begin
      int n;
      int seen;
      repeat (2) @(negedge pclk);
      for (int d = 0; d < 3; d++) begin
         check32($sformatf("reset pready %0d", d), 32'(pready_v[d]), 32'd0);
         check32($sformatf("reset prdata %0d", d), prdata_v[d], 32'd0);
         check32($sformatf("reset pslverr %0d", d), 32'(pslverr_v[d]), 32'd0);
      end
      presetn = 1'b1;

      // Reset while a write sits in its completing cycle.
      @(posedge pclk); #1;
      psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h1234_5678; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      n = 0;
      @(negedge pclk);
      while (!pready_v[0] && n < 40) begin
         n++;
         @(negedge pclk);
      end
      checkint("pre-reset wait", n, 2);
      presetn = 1'b0;
      #1;
      check32("reset drops pready", 32'(pready_v[0]), 32'd0);
      check32("reset drops pslverr", 32'(pslverr_v[0]), 32'd0);
      psel = '0; penable = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      xfer(0, 0, 32'h04, 0, 4'h0, 32'h0, 0, "rd 04 after reset");
      go_idle(0, "r04");

      // WAIT_CYCLES=2 data path, strobes and errors
      xfer(0, 1, 32'h08, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, "wr 08");
      go_idle(0, "w08");
      xfer(0, 0, 32'h08, 0, 4'h0, 32'hDEAD_BEEF, 0, "rd 08");
      xfer(0, 0, 32'h0B, 0, 4'h0, 32'hDEAD_BEEF, 0, "rd 0B lsbs ignored");
      xfer(0, 1, 32'h0C, 32'h1122_3344, 4'hF, 32'h0, 0, "wr 0C full");
      xfer(0, 1, 32'h0C, 32'hAABB_CCDD, 4'b0101, 32'h0, 0, "wr 0C strb");
      xfer(0, 0, 32'h0C, 0, 4'h0, 32'h11BB_33DD, 0, "rd 0C merged");
      xfer(0, 0, 32'h00, 0, 4'h0, ID, 0, "rd id");
      xfer(0, 1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, "wr id err");
      xfer(0, 0, 32'h00, 0, 4'h0, ID, 0, "rd id again");
      xfer(0, 0, 32'h20, 0, 4'h0, 32'h0, 1, "rd 20 err");
      xfer(0, 1, 32'h1C, 32'h0BAD_F00D, 4'hF, 32'h0, 0, "wr 1C last");
      xfer(0, 0, 32'h1C, 0, 4'h0, 32'h0BAD_F00D, 0, "rd 1C last");
      go_idle(0, "r1C");

      // WAIT_CYCLES=0, back-to-back
      xfer(1, 1, 32'h04, 32'h1111_0001, 4'hF, 32'h0, 0, "z wr 04");
      xfer(1, 0, 32'h08, 0, 4'h0, 32'h0, 0, "z rd 08 empty");
      xfer(1, 1, 32'h08, 32'h2222_0002, 4'hF, 32'h0, 0, "z wr 08");
      xfer(1, 0, 32'h04, 0, 4'h0, 32'h1111_0001, 0, "z rd 04");
      xfer(1, 0, 32'h08, 0, 4'h0, 32'h2222_0002, 0, "z rd 08");
      go_idle(1, "z");

      // WAIT_CYCLES=3, abort after one ACCESS cycle
      @(posedge pclk); #1;
      psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check32("abort access pready", 32'(pready_v[2]), 32'd0);
      @(posedge pclk); #1;
      psel = '0; penable = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge pclk);
         if (pready_v[2]) seen++;
      end
      checkint("abort pready never", seen, 0);
      xfer(2, 0, 32'h10, 0, 4'h0, 32'h0, 0, "rd 10 after abort");
      xfer(2, 1, 32'h10, 32'h5A5A_A5A5, 4'hF, 32'h0, 0, "wr 10 w3");
      xfer(2, 0, 32'h10, 0, 4'h0, 32'h5A5A_A5A5, 0, "rd 10 w3");
      go_idle(2, "w3");

      checkint("scoreboard drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
